// File: rtl/hps_cmd_bridge.sv
// HPS-to-coprocessor command bridge: synchronised PIO inputs, a four-phase
// ENABLE/DONE handshake, burst image writes, processing wait with timeout.
module hps_cmd_bridge #(
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 32,
  parameter int PIX_W       = 8,
  parameter int IMG_DEPTH   = 19200,
  parameter int REG_AW      = 2,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic              CLOCK_50,
  input  logic              hps_reset,
  input  logic [31:0]       ctrl_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [31:0]       status_out,
  output logic [ADDR_W-1:0] img_wraddr,
  output logic [PIX_W-1:0]  img_wrdata,
  output logic              img_wren,
  output logic [REG_AW-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wrdata,
  output logic              reg_wren,
  output logic              start_pulse,
  input  logic              proc_busy,
  input  logic              proc_done
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  localparam logic [5:0] CMD_NOP       = 6'h00;
  localparam logic [5:0] CMD_IMG_WRITE = 6'h01;
  localparam logic [5:0] CMD_REG_WRITE = 6'h02;
  localparam logic [5:0] CMD_START     = 6'h04;
  localparam logic [5:0] CMD_IMG_BURST = 6'h08;
  localparam logic [5:0] CMD_SET_PTR   = 6'h10;

  localparam logic [2:0] ERR_OK      = 3'd0;
  localparam logic [2:0] ERR_UNKNOWN = 3'd1;
  localparam logic [2:0] ERR_ADDR    = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT = 3'd3;
  localparam logic [2:0] ERR_BUSY    = 3'd4;

  localparam logic [15:0]       DEPTH16  = 16'(IMG_DEPTH);
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(IMG_DEPTH - 1);
  // The counter is compared one step early so the DONE transition lands on
  // the edge where it would reach TIMEOUT_CYC-1.
  localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT_CYC - 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WAIT_PROC,
    S_DONE
  } state_t;

  // Only enable, cmd and addr are synchronised; the remaining control bits
  // carry no meaning.
  logic unused_ctrl_bits;
  assign unused_ctrl_bits = ^{ctrl_in[31], ctrl_in[29:21]};

  logic [21:0]       ctrl_s1_q, ctrl_s2_q;
  logic [DATA_W-1:0] data_s1_q, data_s2_q;
  logic [1:0]        sync_vld_q;

  always_ff @(posedge CLOCK_50 or posedge hps_reset) begin
    if (hps_reset) begin
      ctrl_s1_q  <= '0;
      ctrl_s2_q  <= '0;
      data_s1_q  <= '0;
      data_s2_q  <= '0;
      sync_vld_q <= '0;
    end else begin
      ctrl_s1_q  <= {ctrl_in[30], ctrl_in[20:15], ctrl_in[14:0]};
      ctrl_s2_q  <= ctrl_s1_q;
      data_s1_q  <= data_in;
      data_s2_q  <= data_s1_q;
      sync_vld_q <= {sync_vld_q[0], 1'b1};
    end
  end

  logic              en_s;
  logic [5:0]        cmd_s;
  logic [14:0]       addr_s;
  logic              addr_ok_s;

  assign en_s      = ctrl_s2_q[21];
  assign cmd_s     = ctrl_s2_q[20:15];
  assign addr_s    = ctrl_s2_q[14:0];
  assign addr_ok_s = ({1'b0, addr_s} < DEPTH16);

  state_t            state_q;
  logic              arm_q;
  logic [5:0]        cmd_q;
  logic [14:0]       addr_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              wrap_q;
  logic [2:0]        err_q;
  logic [7:0]        cmd_cnt_q;
  logic [CNT_W-1:0]  tmo_q;
  logic              done_q;
  logic              img_wren_q, reg_wren_q, start_q;
  logic [ADDR_W-1:0] img_wraddr_q;
  logic [PIX_W-1:0]  img_wrdata_q;
  logic [REG_AW-1:0] reg_addr_q;
  logic [DATA_W-1:0] reg_wrdata_q;
  logic              addr_ok_q;

  assign addr_ok_q = ({1'b0, addr_q} < DEPTH16);

  always_ff @(posedge CLOCK_50 or posedge hps_reset) begin
    if (hps_reset) begin
      state_q      <= S_IDLE;
      arm_q        <= 1'b0;
      cmd_q        <= '0;
      addr_q       <= '0;
      ptr_q        <= '0;
      wrap_q       <= 1'b0;
      err_q        <= ERR_OK;
      cmd_cnt_q    <= '0;
      tmo_q        <= '0;
      done_q       <= 1'b0;
      img_wren_q   <= 1'b0;
      reg_wren_q   <= 1'b0;
      start_q      <= 1'b0;
      img_wraddr_q <= '0;
      img_wrdata_q <= '0;
      reg_addr_q   <= '0;
      reg_wrdata_q <= '0;
    end else begin
      img_wren_q <= 1'b0;
      reg_wren_q <= 1'b0;
      start_q    <= 1'b0;

      case (state_q)
        S_IDLE: begin
          // Arming needs a genuine low on enable after the synchroniser has
          // filled, so an enable held through reset is never taken as an edge.
          arm_q <= arm_q | (sync_vld_q[1] & ~en_s);
          if (arm_q && en_s) begin
            arm_q   <= 1'b0;
            cmd_q   <= cmd_s;
            addr_q  <= addr_s;
            state_q <= S_EXEC;
            // Strobes are registered here so they are high during EXEC.
            case (cmd_s)
              CMD_IMG_WRITE: begin
                if (addr_ok_s) begin
                  img_wren_q   <= 1'b1;
                  img_wraddr_q <= addr_s[ADDR_W-1:0];
                  img_wrdata_q <= data_s2_q[PIX_W-1:0];
                end
              end
              CMD_REG_WRITE: begin
                reg_wren_q   <= 1'b1;
                reg_addr_q   <= addr_s[REG_AW-1:0];
                reg_wrdata_q <= data_s2_q;
              end
              CMD_START: begin
                start_q <= ~proc_busy;
              end
              CMD_IMG_BURST: begin
                img_wren_q   <= 1'b1;
                img_wraddr_q <= ptr_q;
                img_wrdata_q <= data_s2_q[PIX_W-1:0];
              end
              default: ;
            endcase
          end
        end

        S_EXEC: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
          err_q   <= ERR_OK;
          case (cmd_q)
            CMD_NOP, CMD_REG_WRITE: ;
            CMD_IMG_WRITE: begin
              if (!addr_ok_q) err_q <= ERR_ADDR;
            end
            CMD_START: begin
              if (start_q) begin
                tmo_q   <= '0;
                state_q <= S_WAIT_PROC;
                done_q  <= 1'b0;
              end else begin
                err_q <= ERR_BUSY;
              end
            end
            CMD_IMG_BURST: begin
              if (ptr_q == PTR_LAST) begin
                ptr_q  <= '0;
                wrap_q <= 1'b1;
              end else begin
                ptr_q <= ptr_q + 1'b1;
              end
            end
            CMD_SET_PTR: begin
              if (addr_ok_q) begin
                ptr_q  <= addr_q[ADDR_W-1:0];
                wrap_q <= 1'b0;
              end else begin
                err_q <= ERR_ADDR;
              end
            end
            default: err_q <= ERR_UNKNOWN;
          endcase
        end

        S_WAIT_PROC: begin
          if (proc_done) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            err_q   <= ERR_OK;
          end else if (tmo_q == TMO_LAST) begin
            tmo_q   <= tmo_q + 1'b1;
            state_q <= S_DONE;
            done_q  <= 1'b1;
            err_q   <= ERR_TIMEOUT;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end

        S_DONE: begin
          if (!en_s) begin
            state_q   <= S_IDLE;
            done_q    <= 1'b0;
            arm_q     <= 1'b1;
            cmd_cnt_q <= cmd_cnt_q + 1'b1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign img_wraddr  = img_wraddr_q;
  assign img_wrdata  = img_wrdata_q;
  assign img_wren    = img_wren_q;
  assign reg_addr    = reg_addr_q;
  assign reg_wrdata  = reg_wrdata_q;
  assign reg_wren    = reg_wren_q;
  assign start_pulse = start_q;

  assign status_out = {16'(ptr_q), cmd_cnt_q, wrap_q, err_q, proc_busy,
                       (state_q != S_IDLE), done_q, 1'b1};

endmodule

// File: tb/tb_hps_cmd_bridge.sv
// Directed bench for hps_cmd_bridge; a second instance with a short timeout
// covers the processing-wait timeout.
module tb_hps_cmd_bridge;

  logic        CLOCK_50;
  logic        hps_reset;
  logic [31:0] ctrl_in;
  logic [31:0] data_in;
  logic        proc_busy;
  logic        proc_done;
  logic        proc_done_t;

  logic [31:0] status_out;
  logic [14:0] img_wraddr;
  logic [7:0]  img_wrdata;
  logic        img_wren;
  logic [1:0]  reg_addr;
  logic [31:0] reg_wrdata;
  logic        reg_wren;
  logic        start_pulse;

  logic [31:0] status_t;
  logic [14:0] img_wraddr_t;
  logic [7:0]  img_wrdata_t;
  logic        img_wren_t;
  logic [1:0]  reg_addr_t;
  logic [31:0] reg_wrdata_t;
  logic        reg_wren_t;
  logic        start_pulse_t;

  int total = 0;
  int bad   = 0;

  hps_cmd_bridge dut (
    .CLOCK_50(CLOCK_50), .hps_reset(hps_reset), .ctrl_in(ctrl_in), .data_in(data_in),
    .status_out(status_out), .img_wraddr(img_wraddr), .img_wrdata(img_wrdata),
    .img_wren(img_wren), .reg_addr(reg_addr), .reg_wrdata(reg_wrdata),
    .reg_wren(reg_wren), .start_pulse(start_pulse), .proc_busy(proc_busy),
    .proc_done(proc_done)
  );

  hps_cmd_bridge #(.TIMEOUT_CYC(64)) dut_to (
    .CLOCK_50(CLOCK_50), .hps_reset(hps_reset), .ctrl_in(ctrl_in), .data_in(data_in),
    .status_out(status_t), .img_wraddr(img_wraddr_t), .img_wrdata(img_wrdata_t),
    .img_wren(img_wren_t), .reg_addr(reg_addr_t), .reg_wrdata(reg_wrdata_t),
    .reg_wren(reg_wren_t), .start_pulse(start_pulse_t), .proc_busy(proc_busy),
    .proc_done(proc_done_t)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Drives one full handshake and reports what the main instance did:
  // cycles from raw enable to done, strobe counts, cycles from enable drop to done low.
  task automatic do_cmd(input logic [5:0] cmd, input logic [14:0] addr, input logic [31:0] data,
                        output int done_cyc, output int n_img, output int n_reg,
                        output int n_start, output int rel_cyc);
    ctrl_in = {2'b00, 9'd0, cmd, addr};
    data_in = data;
    tick();
    ctrl_in[30] = 1'b1;
    done_cyc = -1; n_img = 0; n_reg = 0; n_start = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (img_wren) n_img++;
      if (reg_wren) n_reg++;
      if (start_pulse) n_start++;
      if (status_out[1] && done_cyc < 0) done_cyc = c;
    end
    ctrl_in[30] = 1'b0;
    rel_cyc = -1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (!status_out[1] && rel_cyc < 0) rel_cyc = c;
    end
  endtask

  task automatic test_reset();
    hps_reset = 1'b1;
    ctrl_in = 32'd0; data_in = 32'd0; proc_busy = 1'b0; proc_done = 1'b0; proc_done_t = 1'b0;
    repeat (3) tick();
    total++;
    if (status_out !== 32'h0000_0001) begin
      bad++; $display("FAIL reset_status: got %h expected 00000001", status_out);
    end
    total++;
    if ({img_wren, reg_wren, start_pulse, img_wraddr, img_wrdata, reg_addr, reg_wrdata} !== '0) begin
      bad++; $display("FAIL reset_outputs: got nonzero strobe/data outputs expected all 0");
    end
    hps_reset = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reg_write();
    int dc, ni, nr, ns, rc;
    do_cmd(6'h02, 15'd1, 32'h0000_0005, dc, ni, nr, ns, rc);
    $display("reg_write: done_cyc=%0d reg_wren=%0d rel=%0d status=%h", dc, nr, rc, status_out);
    total++;
    if (nr !== 1 || ni !== 0 || ns !== 0) begin
      bad++; $display("FAIL reg_strobes: got reg=%0d img=%0d start=%0d expected 1/0/0", nr, ni, ns);
    end
    total++;
    if (reg_addr !== 2'd1 || reg_wrdata !== 32'h5) begin
      bad++; $display("FAIL reg_data: got addr=%0d data=%h expected 1/00000005", reg_addr, reg_wrdata);
    end
    total++;
    if (dc !== 4) begin bad++; $display("FAIL reg_done_latency: got %0d expected 4", dc); end
    total++;
    if (rc !== 3) begin bad++; $display("FAIL reg_done_release: got %0d expected 3", rc); end
    total++;
    if (status_out[15:8] !== 8'd1 || status_out[6:4] !== 3'd0) begin
      bad++; $display("FAIL reg_count_err: got count=%0d err=%0d expected 1/0", status_out[15:8], status_out[6:4]);
    end
  endtask

  task automatic test_burst_wrap();
    int dc, ni, nr, ns, rc;
    logic [14:0] exp_a [3];
    exp_a[0] = 15'd19198; exp_a[1] = 15'd19199; exp_a[2] = 15'd0;
    do_cmd(6'h10, 15'd19198, 32'd0, dc, ni, nr, ns, rc);
    total++;
    if (status_out[31:16] !== 16'd19198 || status_out[7] !== 1'b0) begin
      bad++; $display("FAIL set_ptr: got ptr=%0d wrap=%b expected 19198/0", status_out[31:16], status_out[7]);
    end
    for (int i = 0; i < 3; i++) begin
      do_cmd(6'h08, 15'd0, 32'hA1 + i, dc, ni, nr, ns, rc);
      $display("burst %0d: wraddr=%0d wrdata=%h img_wren=%0d", i, img_wraddr, img_wrdata, ni);
      total++;
      if (ni !== 1 || img_wraddr !== exp_a[i] || img_wrdata !== 8'(8'hA1 + i)) begin
        bad++; $display("FAIL burst_write%0d: got n=%0d addr=%0d data=%h expected 1/%0d/%h",
                        i, ni, img_wraddr, img_wrdata, exp_a[i], 8'(8'hA1 + i));
      end
    end
    total++;
    if (status_out[31:16] !== 16'd1 || status_out[7] !== 1'b1 || status_out[6:4] !== 3'd0) begin
      bad++; $display("FAIL burst_final: got ptr=%0d wrap=%b err=%0d expected 1/1/0",
                      status_out[31:16], status_out[7], status_out[6:4]);
    end
    total++;
    if (status_out[15:8] !== 8'd5) begin
      bad++; $display("FAIL burst_count: got %0d expected 5", status_out[15:8]);
    end
  endtask

  task automatic test_out_of_range();
    int dc, ni, nr, ns, rc;
    do_cmd(6'h01, 15'd19200, 32'h77, dc, ni, nr, ns, rc);
    $display("img_write 19200: img_wren=%0d done_cyc=%0d err=%0d", ni, dc, status_out[6:4]);
    total++;
    if (ni !== 0 || dc !== 4 || status_out[6:4] !== 3'd2) begin
      bad++; $display("FAIL oor_img_write: got n=%0d done=%0d err=%0d expected 0/4/2", ni, dc, status_out[6:4]);
    end
    do_cmd(6'h10, 15'd19200, 32'd0, dc, ni, nr, ns, rc);
    total++;
    if (status_out[6:4] !== 3'd2 || status_out[31:16] !== 16'd1 || status_out[7] !== 1'b1) begin
      bad++; $display("FAIL oor_set_ptr: got err=%0d ptr=%0d wrap=%b expected 2/1/1",
                      status_out[6:4], status_out[31:16], status_out[7]);
    end
    do_cmd(6'h01, 15'd19199, 32'h5A, dc, ni, nr, ns, rc);
    total++;
    if (ni !== 1 || img_wraddr !== 15'd19199 || img_wrdata !== 8'h5A || status_out[6:4] !== 3'd0) begin
      bad++; $display("FAIL last_addr_write: got n=%0d addr=%0d data=%h err=%0d expected 1/19199/5a/0",
                      ni, img_wraddr, img_wrdata, status_out[6:4]);
    end
    do_cmd(6'h03, 15'd0, 32'd0, dc, ni, nr, ns, rc);
    total++;
    if (status_out[6:4] !== 3'd1 || (ni + nr + ns) !== 0 || dc !== 4) begin
      bad++; $display("FAIL unknown_cmd: got err=%0d strobes=%0d done=%0d expected 1/0/4",
                      status_out[6:4], ni + nr + ns, dc);
    end
    total++;
    if (status_out[15:8] !== 8'd9) begin
      bad++; $display("FAIL oor_count: got %0d expected 9", status_out[15:8]);
    end
  endtask

  task automatic test_start_handshake();
    int np = 0, pc = -1, early = 0;
    logic busy_mid = 1'b0;
    proc_busy = 1'b0;
    ctrl_in = {2'b00, 9'd0, 6'h04, 15'd0};
    tick();
    ctrl_in[30] = 1'b1;
    for (int c = 1; c <= 103; c++) begin
      tick();
      if (start_pulse) begin np++; if (pc < 0) pc = c; end
      if (status_out[1]) early++;
      if (c == 50) busy_mid = status_out[2];
    end
    proc_done = 1'b1;
    tick();
    $display("start: pulses=%0d pulse_cyc=%0d done_after_proc_done=%b err=%0d",
             np, pc, status_out[1], status_out[6:4]);
    total++;
    if (np !== 1 || pc !== 3) begin
      bad++; $display("FAIL start_pulse: got n=%0d cyc=%0d expected 1/3", np, pc);
    end
    total++;
    if (early !== 0 || busy_mid !== 1'b1) begin
      bad++; $display("FAIL start_wait: got early_done=%0d busy=%b expected 0/1", early, busy_mid);
    end
    total++;
    if (status_out[1] !== 1'b1 || status_out[6:4] !== 3'd0) begin
      bad++; $display("FAIL start_done: got done=%b err=%0d expected 1/0", status_out[1], status_out[6:4]);
    end
    proc_done = 1'b0;
    ctrl_in[30] = 1'b0;
    repeat (10) tick();
    total++;
    if (status_out[1] !== 1'b0 || status_out[2] !== 1'b0 || status_out[15:8] !== 8'd10) begin
      bad++; $display("FAIL start_release: got done=%b busy=%b count=%0d expected 0/0/10",
                      status_out[1], status_out[2], status_out[15:8]);
    end
  endtask

  task automatic test_timeout_busy();
    int np = 0, pc = -1, dcy = -1;
    int dc, ni, nr, ns, rc;
    ctrl_in = {2'b00, 9'd0, 6'h04, 15'd0};
    tick();
    ctrl_in[30] = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      tick();
      if (start_pulse_t) begin np++; if (pc < 0) pc = c; end
      if (status_t[1] && dcy < 0) dcy = c;
    end
    $display("timeout: pulse_cyc=%0d done_cyc=%0d err=%0d", pc, dcy, status_t[6:4]);
    total++;
    if (np !== 1 || pc !== 3) begin
      bad++; $display("FAIL timeout_pulse: got n=%0d cyc=%0d expected 1/3", np, pc);
    end
    total++;
    if (dcy !== 67 || status_t[6:4] !== 3'd3) begin
      bad++; $display("FAIL timeout_done: got done_cyc=%0d err=%0d expected 67/3", dcy, status_t[6:4]);
    end
    proc_done = 1'b1;
    tick();
    proc_done = 1'b0;
    ctrl_in[30] = 1'b0;
    repeat (10) tick();

    proc_busy = 1'b1;
    do_cmd(6'h04, 15'd0, 32'd0, dc, ni, nr, ns, rc);
    $display("busy start: pulses=%0d done_cyc=%0d err=%0d", ns, dc, status_out[6:4]);
    total++;
    if (ns !== 0 || dc !== 4 || status_out[6:4] !== 3'd4 || status_out[3] !== 1'b1) begin
      bad++; $display("FAIL busy_reject: got pulses=%0d done=%0d err=%0d pbusy=%b expected 0/4/4/1",
                      ns, dc, status_out[6:4], status_out[3]);
    end
    proc_busy = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    int nstr = 0, nbusy = 0, nr = 0, dcy = -1;
    ctrl_in = {2'b00, 9'd0, 6'h04, 15'd0};
    tick();
    ctrl_in[30] = 1'b1;
    repeat (10) tick();
    total++;
    if (status_out[2] !== 1'b1 || status_out[1] !== 1'b0) begin
      bad++; $display("FAIL rst_pre_wait: got busy=%b done=%b expected 1/0", status_out[2], status_out[1]);
    end
    #3 hps_reset = 1'b1;
    #1;
    $display("reset mid-wait: status=%h wraddr=%0d reg_addr=%0d", status_out, img_wraddr, reg_addr);
    total++;
    if (status_out !== 32'h0000_0001 ||
        {img_wren, reg_wren, start_pulse, img_wraddr, img_wrdata, reg_addr, reg_wrdata} !== '0) begin
      bad++; $display("FAIL rst_immediate: got status=%h wraddr=%0d reg_addr=%0d expected 00000001/0/0",
                      status_out, img_wraddr, reg_addr);
    end
    repeat (3) tick();
    hps_reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (img_wren || reg_wren || start_pulse) nstr++;
      if (status_out[2]) nbusy++;
    end
    total++;
    if (nstr !== 0 || nbusy !== 0) begin
      bad++; $display("FAIL rst_held_enable: got strobes=%0d busy_cycles=%0d expected 0/0", nstr, nbusy);
    end
    ctrl_in[30] = 1'b0;
    repeat (5) tick();
    ctrl_in = {2'b00, 9'd0, 6'h02, 15'd2};
    data_in = 32'h7;
    tick();
    ctrl_in[30] = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (reg_wren) nr++;
      if (status_out[1] && dcy < 0) dcy = c;
    end
    $display("post-reset reg_write: reg_wren=%0d done_cyc=%0d", nr, dcy);
    total++;
    if (nr !== 1 || dcy !== 4 || reg_addr !== 2'd2 || reg_wrdata !== 32'h7) begin
      bad++; $display("FAIL rst_toggle_cmd: got n=%0d done=%0d addr=%0d data=%h expected 1/4/2/00000007",
                      nr, dcy, reg_addr, reg_wrdata);
    end
    ctrl_in[30] = 1'b0;
    repeat (10) tick();
    total++;
    if (status_out[15:8] !== 8'd1) begin
      bad++; $display("FAIL rst_count: got %0d expected 1", status_out[15:8]);
    end
  endtask

  initial begin
    test_reset();
    test_reg_write();
    test_burst_wrap();
    test_out_of_range();
    test_start_handshake();
    test_timeout_busy();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before 2 ms");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/hps_cmd_bridge.md
# hps_cmd_bridge

Parametrised HPS-to-coprocessor command bridge. It sits between the three PIO words and the image RAM, register bank and processing FSM. It replaces level-decoded ENABLE commands with a synchronised four-phase ENABLE/DONE handshake, so each command executes exactly once. It adds burst image writes through an auto-incrementing pointer, a processing-completion wait with timeout, and error reporting.

## Interface
- ADDR_W, 15: image RAM address width (≤15).
- DATA_W, 32: data PIO width.
- PIX_W, 8: pixel width; img_wrdata = data[PIX_W-1:0].
- IMG_DEPTH, 19200: valid image addresses are 0..IMG_DEPTH-1.
- REG_AW, 2: register bank address width.
- TIMEOUT_CYC, 2000000: maximum wait cycles for proc_done.
- CLOCK_50  in  1  system clock, 50 MHz.
- hps_reset  in  1  asynchronous, active-high reset.
- ctrl_in  in  32  control PIO: [30] enable, [20:15] cmd, [14:0] addr; other bits ignored.
- data_in  in  DATA_W  data PIO.
- status_out  out  32  status word to HPS (see Operation).
- img_wraddr  out  ADDR_W  image RAM write address.
- img_wrdata  out  PIX_W  image RAM write data.
- img_wren  out  1  image RAM write strobe, one cycle.
- reg_addr  out  REG_AW  register bank address.
- reg_wrdata  out  DATA_W  register bank write data.
- reg_wren  out  1  register write strobe, one cycle.
- start_pulse  out  1  processing start request, one cycle.
- proc_busy  in  1  processor running.
- proc_done  in  1  processor finished (level or pulse).

## Operation
- **Input synchronisation:** ctrl_in and data_in pass through a 2-FF synchroniser. Only the synchronised copies are used.
- **HPS write ordering:** the HPS writes data_in and cmd/addr before raising enable.
- **Commands:**
  - 0x00 NOP.
  - 0x01 IMG_WRITE: write at addr.
  - 0x02 REG_WRITE: write at addr[REG_AW-1:0].
  - 0x04 START.
  - 0x08 IMG_BURST: write at ptr, then ptr+1.
  - 0x10 SET_PTR: ptr ← addr.
  - Any other value is unknown and sets err code 1.
- **States:** IDLE, EXEC, WAIT_PROC, DONE.
- **IDLE:**
  - On the first cycle that synchronised enable is 1, capture cmd, addr and data into holding registers and go to EXEC.
  - Enable already high when reset is released is not an edge. The bridge waits for enable=0 first.
- **EXEC (one cycle):**
  - Drive exactly one strobe per command.
  - START with proc_busy=1: err 4, no pulse.
  - START otherwise: pulse, clear the timeout counter, go to WAIT_PROC.
  - All other commands go to DONE.
- **WAIT_PROC:**
  - proc_done=1: go to DONE with err 0.
  - Counter reaches TIMEOUT_CYC-1: go to DONE with err 3.
- **DONE:** done=1 is held until synchronised enable=0, then the block returns to IDLE.
- **Address errors (err 2, no write, ptr unchanged):**
  - IMG_WRITE with addr ≥ IMG_DEPTH.
  - SET_PTR with addr ≥ IMG_DEPTH.
- **Burst pointer wrap:** at ptr = IMG_DEPTH-1, IMG_BURST writes and then ptr wraps to 0 and sets sticky wrap_flag. SET_PTR clears wrap_flag.
- **Error codes:** err_code [2:0] is set on every command completion; 0 means success.
- **Command counter:** 8-bit cmd_count increments on each IDLE entry from DONE, including errored commands, and wraps 255 → 0.
- **status_out layout:**
  - [31:16] ptr, zero-extended.
  - [15:8] cmd_count.
  - [7] wrap_flag.
  - [6:4] err_code.
  - [3] proc_busy, passed through.
  - [2] busy (state ≠ IDLE).
  - [1] done.
  - [0] constant 1.

## Timing
- **Reset:** all state is cleared, state=IDLE, and every output is 0 except status_out[0]=1.
- **Reset assertion mid-operation:** aborts immediately. No strobe is issued afterwards.
- **Latency, raw enable rise at cycle 0:**
  - Synchronised enable at cycle 2.
  - EXEC at cycle 3, when img_wren, reg_wren or start_pulse is high.
  - done=1 at cycle 4, for non-START commands.
- **Write strobes:** img_wraddr and img_wrdata are valid in the same cycle as img_wren and remain stable until the next EXEC.
- **Done release:** done falls 3 cycles after raw enable falls.
- **Next command:** a new command is accepted no earlier than the cycle after the IDLE entry.
- **Enable dropped in EXEC or WAIT_PROC:** the command still completes. DONE is entered and left one cycle later.
- **proc_done during EXEC:** ignored. Only WAIT_PROC samples it.
- **Timeout counter:** width is $clog2(TIMEOUT_CYC).

## Test plan
- **Single register write:** reset, then REG_WRITE addr=1 data=0x00000005 with enable held 20 cycles. Require exactly one reg_wren, reg_addr=1, done=1 at +4, cmd_count=1.
- **Burst with wrap:** SET_PTR 19198, then 3× IMG_BURST with data 0xA1, 0xA2, 0xA3. Require writes at 19198, 19199 and 0; ptr=1; wrap_flag=1; err=0.
- **Out-of-range write:** IMG_WRITE addr=19200. Require no img_wren, err_code=2, done=1.
- **START handshake:** START with proc_busy=0 and proc_done raised 100 cycles after start_pulse. Require a single start_pulse, done rising 1 cycle after proc_done, err=0.
- **Timeout and busy reject:** START with TIMEOUT_CYC=64 and proc_done never asserted. Require err_code=3 and done at 64 cycles after EXEC. START with proc_busy=1 gives err_code=4 and no start_pulse.
- **Reset mid-wait:** assert hps_reset during WAIT_PROC. Require all outputs 0 immediately. Enable high at release produces no command until it is toggled.
